// File: rtl/ckt_sweep_ctrl.sv
// Sweeps all 2**N_IN vectors into ckt, samples y into table_out, compares against a latched golden table.
// Latency: done 2**N_IN*(SETTLE+1) cycles after accepted start; start ignored while busy; early abort via CKT_SWEEP_ABORT_EN.
module ckt_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2**N_IN-1:0] golden,
  output logic [N_IN-1:0]    dut_in,
  input  logic               dut_y,
  output logic               busy,
  output logic               done,
  output logic [2**N_IN-1:0] table_out,
  output logic               pass,
  output logic [N_IN-1:0]    fail_idx
);

  localparam int NV    = 2**N_IN;
  localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(S_EFF - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [N_IN-1:0] idx_q;
  logic [CW-1:0]   cnt_q;
  logic [NV-1:0]   golden_q;
  logic            fail_flag_q;
  logic            mismatch;
  logic            abort_now;
  logic            sample_exit;

  // The vector index doubles as the driven stimulus, so it holds the last vector after a sweep.
  assign dut_in   = idx_q;
  assign mismatch = (dut_y != golden_q[idx_q]);

`ifdef CKT_SWEEP_ABORT_EN
  assign abort_now = mismatch && !fail_flag_q;
`else
  assign abort_now = 1'b0;
`endif

  assign sample_exit = (idx_q == IDX_LAST) || abort_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_APPLY;
      S_APPLY:  if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = sample_exit ? S_DONE : S_APPLY;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      golden_q    <= '0;
      fail_flag_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_out   <= '0;
      pass        <= 1'b0;
      fail_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            golden_q    <= golden;
            fail_flag_q <= 1'b0;
            busy        <= 1'b1;
            table_out   <= '0;
            pass        <= 1'b0;
            fail_idx    <= '0;
          end
        end
        S_APPLY: begin
          if (cnt_q == CNT_LAST) cnt_q <= '0;
          else                   cnt_q <= cnt_q + CW'(1);
        end
        S_SAMPLE: begin
          table_out[idx_q] <= dut_y;
          if (mismatch && !fail_flag_q) begin
            fail_idx    <= idx_q;
            fail_flag_q <= 1'b1;
          end
          // Verdict folds in this cycle's sample so the last vector counts.
          if (sample_exit) begin
            done <= 1'b1;
            pass <= !(fail_flag_q || mismatch);
          end else begin
            idx_q <= idx_q + N_IN'(1);
            cnt_q <= '0;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
